// File: rtl/fp32_serdes_if.sv
// Pin-side byte streams, operand/result words to the external fp32 adder, and status for fp32_serdes.
// The slave modport is the serdes itself; the master modport is its environment.
interface fp32_serdes_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] sum;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    modport master (
        output in_byte, in_valid, sum, out_ready,
        input  in_ready, op_a, op_b, out_byte, out_valid, busy
    );

    modport slave (
        input  in_byte, in_valid, sum, out_ready,
        output in_ready, op_a, op_b, out_byte, out_valid, busy
    );
endinterface

// File: rtl/fp32_serdes.sv
// Byte-serial front end for an external fp32 adder: loads two operands little-endian, returns the sum as 4 bytes.
// Define FP32_SERDES_PIPE_EN to register the adder result through an extra CALC2 stage.
module fp32_serdes (
    input  logic         clk,
    input  logic         rst,
    fp32_serdes_if.slave bus
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CALC  = 2'd1,
`ifdef FP32_SERDES_PIPE_EN
        CALC2 = 2'd2,
`endif
        SEND  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  in_idx;
    logic [1:0]  out_idx;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;
`ifdef FP32_SERDES_PIPE_EN
    logic [31:0] pipe;
`endif

    logic in_take;
    logic out_take;

    assign in_take  = bus.in_valid && (state == LOAD);
    assign out_take = bus.out_ready && (state == SEND);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            LOAD: if (in_take && (in_idx == 3'd7)) state_next = CALC;
`ifdef FP32_SERDES_PIPE_EN
            CALC:  state_next = CALC2;
            CALC2: state_next = SEND;
`else
            CALC:  state_next = SEND;
`endif
            SEND: if (out_take && (out_idx == 2'd3)) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_idx  <= 3'd0;
            out_idx <= 2'd0;
            op_a    <= 32'h0;
            op_b    <= 32'h0;
            result  <= 32'h0;
`ifdef FP32_SERDES_PIPE_EN
            pipe    <= 32'h0;
`endif
        end else begin
            // Operands are written byte by byte, so they only change once a new load starts.
            if (in_take) begin
                in_idx <= in_idx + 3'd1;
                if (!in_idx[2]) op_a[{in_idx[1:0], 3'b000} +: 8] <= bus.in_byte;
                else            op_b[{in_idx[1:0], 3'b000} +: 8] <= bus.in_byte;
            end
`ifdef FP32_SERDES_PIPE_EN
            if (state == CALC)  pipe   <= bus.sum;
            if (state == CALC2) result <= pipe;
`else
            if (state == CALC)  result <= bus.sum;
`endif
            if (out_take) out_idx <= out_idx + 2'd1;
        end
    end

    assign bus.in_ready  = (state == LOAD);
    assign bus.out_valid = (state == SEND);
    assign bus.out_byte  = (state == SEND) ? result[{out_idx, 3'b000} +: 8] : 8'h00;
    assign bus.op_a      = op_a;
    assign bus.op_b      = op_b;
    assign bus.busy      = !((state == LOAD) && (in_idx == 3'd0));

endmodule

// File: tb/tb_fp32_serdes.sv
// Scoreboard bench for fp32_serdes: stimulus pushes expected result bytes, a negedge monitor pops and compares.
// Honours FP32_SERDES_PIPE_EN for the expected load-to-output latency.
module tb_fp32_serdes;

`ifdef FP32_SERDES_PIPE_EN
    localparam int EXP_LAT = 3;
`else
    localparam int EXP_LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [7:0] exp_q[$];

    fp32_serdes_if bus();

    fp32_serdes dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output byte must match the oldest expected byte; outside SEND the byte is 0.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0)
                    check("out_valid unexpected", {31'b0, bus.out_valid}, 32'd0);
                else if (bus.out_ready)
                    check("out_byte", {24'b0, bus.out_byte}, {24'b0, exp_q.pop_front()});
                else
                    check("out_byte stall", {24'b0, bus.out_byte}, {24'b0, exp_q[0]});
            end else begin
                check("idle out_byte", {24'b0, bus.out_byte}, 32'd0);
            end
        end
    end

    task automatic post_reset_checks(input string tag);
        @(negedge clk);
        check({tag, " busy"},      {31'b0, bus.busy},      32'd0);
        check({tag, " in_ready"},  {31'b0, bus.in_ready},  32'd1);
        check({tag, " out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        check({tag, " op_a"},      bus.op_a, 32'd0);
        check({tag, " op_b"},      bus.op_b, 32'd0);
    endtask

    // One transaction. gap<0 means random idle cycles (0..2) before each byte.
    // abort_load >= 0 resets after that many bytes; abort_send >= 0 resets once that many bytes remain.
    task automatic run_txn(input logic [63:0] data, input logic [31:0] s, input int gap,
                           input int stall, input bit rnd_ready, input bit pulse,
                           input int abort_load, input int abort_send);
        int idle;
        int lat;
        int cyc;
        int stall_left;
        bus.sum       = s;
        bus.out_ready = (stall > 0) ? 1'b0 : 1'b1;
        stall_left    = (stall > 0) ? stall - 1 : 0;
        for (int i = 0; i < 8; i++) begin
            if (i == abort_load) begin
                bus.in_valid = 1'b1;
                bus.in_byte  = 8'($urandom);
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                bus.in_valid = 1'b0;
                post_reset_checks("load abort");
                @(posedge clk); #1;
                return;
            end
            idle = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < idle; k++) begin
                bus.in_valid = 1'b0;
                bus.in_byte  = 8'($urandom);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_byte  = data[8*i +: 8];
            @(negedge clk);
            check("in_ready load", {31'b0, bus.in_ready}, 32'd1);
            check("busy load", {31'b0, bus.busy}, (i != 0) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        for (int b = 0; b < 4; b++) exp_q.push_back(s[8*b +: 8]);
        bus.in_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.in_byte  = 8'($urandom);

        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid || lat >= 20) break;
            check("in_ready calc", {31'b0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
            if (pulse) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_byte  = 8'($urandom);
            end
        end
        check("latency", lat, EXP_LAT);
        check("op_a", bus.op_a, data[31:0]);
        check("op_b", bus.op_b, data[63:32]);
        check("in_ready send", {31'b0, bus.in_ready}, 32'd0);

        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            bus.sum = $urandom;
            if (abort_send >= 0 && exp_q.size() == abort_send) begin
                rst = 1'b1;
                bus.out_ready = 1'b1;
                exp_q.delete();
                @(posedge clk); #1;
                rst = 1'b0;
                bus.in_valid = 1'b0;
                post_reset_checks("send abort");
                repeat (3) @(posedge clk);
                #1;
                return;
            end
            if (stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (pulse) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_byte  = 8'($urandom);
            end
        end
        if (exp_q.size() != 0) begin
            check("send timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_byte   = 8'h00;
        bus.out_ready = 1'b0;
        bus.sum       = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        post_reset_checks("reset");
        @(posedge clk); #1;

        // Directed: 1.0 + 1.0 operands, stubbed sum, free-running consumer.
        run_txn(64'h3F800000_3F800000, 32'h12345678, 0, 0, 1'b0, 1'b0, -1, -1);
        // Consumer stalls 5 cycles on the first byte.
        run_txn(64'h3F800000_3F800000, 32'h12345678, 0, 5, 1'b0, 1'b0, -1, -1);
        // Valid one cycle in three during load; in_valid noise during CALC/SEND.
        run_txn(64'h3F800000_3F800000, 32'h12345678, 2, 0, 1'b0, 1'b1, -1, -1);
        // Reset after five bytes, then a fresh load.
        run_txn(64'h11223344_55667788, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0, 5, -1);
        run_txn(64'hC0490FDB_40490FDB, 32'h0BADF00D, 0, 0, 1'b0, 1'b0, -1, -1);
        // Reset once bytes 0 and 1 have been taken.
        run_txn(64'h40000000_3F800000, 32'h40400000, 0, 0, 1'b0, 1'b0, -1, 2);
        // Back-to-back transactions with different results.
        run_txn(64'h01234567_89ABCDEF, 32'hAABBCCDD, 0, 0, 1'b0, 1'b0, -1, -1);
        run_txn(64'hFEDCBA98_76543210, 32'h01020304, 0, 0, 1'b0, 1'b0, -1, -1);
        // Random operands, sums, gaps, consumer backpressure and input noise.
        for (int t = 0; t < 24; t++)
            run_txn({$urandom, $urandom}, $urandom, -1, int'($urandom_range(0, 3)),
                    1'b1, 1'($urandom_range(0, 1)), -1, -1);

        repeat (4) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp32_serdes.md
FP32_SERDES -- requirements
Module: fp32_serdes

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_byte  in  8  operand byte from pins.
REQ-005 in_valid  in  1  in_byte valid this cycle.
REQ-006 in_ready  out  1  block accepts a byte this cycle.
REQ-007 op_a  out  32  operand A word driven to downstream fp32 adder.
REQ-008 op_b  out  32  operand B word driven to downstream fp32 adder.
REQ-009 sum  in  32  combinational adder result for op_a/op_b.
REQ-010 out_byte  out  8  result byte to pins.
REQ-011 out_valid  out  1  out_byte valid.
REQ-012 out_ready  in  1  consumer takes out_byte this cycle.
REQ-013 busy  out  1  high in any state other than LOAD with byte index 0.

Function
REQ-014 The FSM SHALL have states LOAD, CALC, SEND, plus CALC2 only when FP32_SERDES_PIPE_EN is defined.
REQ-015 LOAD: in_ready=1. A byte is accepted when in_valid&&in_ready; a 3-bit index counts accepted bytes 0..7.
REQ-016 Bytes SHALL be little-endian: index 0-3 fill op_a[7:0]..op_a[31:24], index 4-7 fill op_b[7:0]..op_b[31:24].
REQ-017 Accepting byte 7 SHALL move LOAD->CALC next cycle and wrap the index to 0.
REQ-018 in_ready=0 outside LOAD; in_valid there SHALL be ignored with no state change.
REQ-019 op_a/op_b SHALL hold stable from CALC until re-entry into LOAD byte 0 overwrites them.
REQ-020 CALC (macro undefined): capture sum into 32-bit result register; next state SEND. Exactly 1 cycle.
REQ-021 SEND: out_valid=1, out_byte=result byte selected by 2-bit index (0 = bits[7:0]).
REQ-022 out_valid&&out_ready SHALL advance the index; the handshake on byte 3 SHALL return to LOAD with index 0.
REQ-023 out_ready low SHALL stall SEND holding out_byte/index stable; no timeout.
REQ-024 out_valid=0 and out_byte=0 outside SEND.
REQ-025 Latency: last input byte accepted in cycle N -> first out_valid in cycle N+2 (N+3 with macro).
REQ-026 Next operand load SHALL be possible the cycle after the final output handshake; no overlap of LOAD and SEND.

Reset
REQ-027 rst high at a clock edge, in any state, mid-byte or mid-SEND, SHALL force LOAD, indices 0, op_a=op_b=result=0, out_valid=0, out_byte=0, in_ready=1 next cycle.
REQ-028 rst SHALL take priority over simultaneous in_valid or out_ready; partial words are discarded.

Configuration
REQ-029 Macro FP32_SERDES_PIPE_EN defined: CALC registers sum into a pipeline register, CALC2 copies it into result, then SEND (2 cycles). Undefined: no CALC2, single-cycle CALC per REQ-020.

Verification
REQ-030 Bytes 00 00 80 3F 00 00 80 3F with sum stubbed 0x12345678, out_ready=1 -> op_a=op_b=0x3F800000; out bytes 78,56,34,12; first out_valid at N+2 (N+3 with macro).
REQ-031 Same load, out_ready held 0 for 5 cycles in SEND -> out_byte stays 0x78, out_valid stays 1; then 78,56,34,12 in order.
REQ-032 in_valid gaps (1 of every 3 cycles) during load -> identical op_a/op_b to REQ-030; in_valid pulsed during SEND -> no effect.
REQ-033 rst asserted after 5 bytes accepted -> next cycle LOAD, op_a=0, busy=0; subsequent fresh 8-byte load produces correct words.
REQ-034 rst asserted during SEND after byte 1 -> out_valid=0 next cycle; no further result bytes emitted.
REQ-035 Two back-to-back transactions with different stubbed sums (0xAABBCCDD, 0x01020304) -> outputs DD,CC,BB,AA then 04,03,02,01 with no stale data.
